pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: forwarding selects, load-use/branch stalls, memory-wait stalls.
// Latency: forwarding, stall and flush outputs are combinational (0 cycles); StallCycles/MemTimeout update on CLK.
// Backpressure: a pending data-memory access (MemReqM without MemReadyM) freezes F..M and bubbles W until ready.
// Optional feature: define HZ_MEM_TIMEOUT_EN to build the sticky memory-wait watchdog behind MemTimeout.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT_CYC = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemToRegE,
    input  logic        MemToRegM,
    input  logic        BranchD,
    input  logic        BranchTakenD,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [15:0] StallCycles,
    output logic        MemTimeout
);

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    logic wr_m_valid;
    logic wr_w_valid;
    logic wr_e_valid;
    logic lwstall;
    logic brstall;
    logic memstall;
    logic hzstall;

    // Out-of-range watchdog limits are rejected at elaboration time.
    if ((MEM_TIMEOUT_CYC < 1) || (MEM_TIMEOUT_CYC > 255)) begin : g_bad_mem_timeout_cyc
        $error("pipe_hazard_ctrl: MEM_TIMEOUT_CYC must be within 1..255");
    end

    assign wr_m_valid = RegWriteM & (WriteRegM != 5'd0);
    assign wr_w_valid = RegWriteW & (WriteRegW != 5'd0);
    assign wr_e_valid = RegWriteE & (WriteRegE != 5'd0);

    // Operand forwarding: the younger M-stage result takes precedence over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;

        if (wr_m_valid && (WriteRegM == RsE)) begin
            ForwardAE = 2'b10;
        end else if (wr_w_valid && (WriteRegW == RsE)) begin
            ForwardAE = 2'b01;
        end

        if (wr_m_valid && (WriteRegM == RtE)) begin
            ForwardBE = 2'b10;
        end else if (wr_w_valid && (WriteRegW == RtE)) begin
            ForwardBE = 2'b01;
        end

        ForwardAD = wr_m_valid && (WriteRegM == RsD);
        ForwardBD = wr_m_valid && (WriteRegM == RtD);
    end

    // Data hazards that forwarding cannot cover: load-use, and branch operands still in flight.
    always_comb begin
        lwstall = 1'b0;
        brstall = 1'b0;

        lwstall = MemToRegE && RegWriteE && (WriteRegE != 5'd0)
                  && ((WriteRegE == RsD) || (WriteRegE == RtD));

        brstall = BranchD
                  && ((wr_e_valid && ((WriteRegE == RsD) || (WriteRegE == RtD)))
                      || (MemToRegM && (WriteRegM != 5'd0)
                          && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    end

    assign hzstall = lwstall | brstall;

    // Memory-wait state register; reset abandons any outstanding wait.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stall/flush priority: memory wait, then data hazards, then taken-branch flush.
    always_comb begin
        state_nxt = state;
        memstall  = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;

        case (state)
            RUN: begin
                memstall = MemReqM && !MemReadyM;
                if (MemReqM && !MemReadyM) begin
                    state_nxt = MEMWAIT;
                end
            end
            MEMWAIT: begin
                // Release is combinational on MemReadyM so no extra bubble is added.
                memstall = !MemReadyM;
                if (MemReadyM) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (memstall) begin
            // Whole front of the pipe freezes; W gets a bubble while M waits on memory.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (hzstall) begin
            // Hold F/D and inject a bubble into E; the hazard is re-checked next cycle.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (BranchTakenD) begin
            FlushD = 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            StallCycles <= 16'd0;
        end else if (StallF && (StallCycles != 16'hFFFF)) begin
            StallCycles <= StallCycles + 16'd1;
        end
    end

`ifdef HZ_MEM_TIMEOUT_EN
    localparam logic [8:0] TMO_LIMIT = 9'(MEM_TIMEOUT_CYC);

    logic [7:0] tmo_cnt;
    logic [8:0] tmo_cnt_inc;

    assign tmo_cnt_inc = {1'b0, tmo_cnt} + 9'd1;

    // Watchdog: counts not-ready cycles of one memory wait; the flag stays set until reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt    <= 8'd0;
            MemTimeout <= 1'b0;
        end else begin
            if ((state == RUN) && (state_nxt == MEMWAIT)) begin
                tmo_cnt <= 8'd0;
            end else if ((state == MEMWAIT) && !MemReadyM) begin
                if (tmo_cnt != 8'hFF) begin
                    tmo_cnt <= tmo_cnt_inc[7:0];
                end
                if (tmo_cnt_inc >= TMO_LIMIT) begin
                    MemTimeout <= 1'b1;
                end
            end
        end
    end
`else
    assign MemTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
    logic        BranchD, BranchTakenD, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [15:0] StallCycles;
    logic        MemTimeout;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.MEM_TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .BranchD(BranchD), .BranchTakenD(BranchTakenD),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .StallCycles(StallCycles), .MemTimeout(MemTimeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: "is a memory access outstanding", stall-cycle tally, length of current wait.
    bit m_waiting;
    int m_stalls;
    int m_wait_len;
    bit m_tmo;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes(input bit we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] src);
        if (writes(RegWriteM, WriteRegM, src)) return 2'd2;
        if (writes(RegWriteW, WriteRegW, src)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit mem_busy();
        return (MemReqM || m_waiting) && !MemReadyM;
    endfunction

    function automatic bit data_hazard();
        bit lw, br;
        lw = MemToRegE && (writes(RegWriteE, WriteRegE, RsD) || writes(RegWriteE, WriteRegE, RtD));
        br = BranchD && (writes(RegWriteE, WriteRegE, RsD) || writes(RegWriteE, WriteRegE, RtD)
                         || writes(MemToRegM, WriteRegM, RsD) || writes(MemToRegM, WriteRegM, RtD));
        return lw || br;
    endfunction

    function automatic bit exp_tmo();
`ifdef HZ_MEM_TIMEOUT_EN
        return m_tmo;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_waiting  = 0;
        m_stalls   = 0;
        m_wait_len = 0;
        m_tmo      = 0;
    endtask

    task automatic check_model(input string tag);
        bit mem, hz;
        mem = mem_busy();
        hz  = data_hazard();
        chk({tag, ".fae"}, 16'(ForwardAE), 16'(fwd_e(RsE)));
        chk({tag, ".fbe"}, 16'(ForwardBE), 16'(fwd_e(RtE)));
        chk({tag, ".fad"}, 16'(ForwardAD), 16'(writes(RegWriteM, WriteRegM, RsD)));
        chk({tag, ".fbd"}, 16'(ForwardBD), 16'(writes(RegWriteM, WriteRegM, RtD)));
        chk({tag, ".sf"},  16'(StallF), 16'(mem || hz));
        chk({tag, ".sd"},  16'(StallD), 16'(mem || hz));
        chk({tag, ".se"},  16'(StallE), 16'(mem));
        chk({tag, ".sm"},  16'(StallM), 16'(mem));
        chk({tag, ".fw"},  16'(FlushW), 16'(mem));
        chk({tag, ".fe"},  16'(FlushE), 16'(!mem && hz));
        chk({tag, ".fd"},  16'(FlushD), 16'(!mem && !hz && BranchTakenD));
        chk({tag, ".cnt"}, StallCycles, 16'(m_stalls));
        chk({tag, ".tmo"}, 16'(MemTimeout), 16'(exp_tmo()));
    endtask

    // Advance one rising edge; the model absorbs the inputs present at that edge.
    task automatic tick();
        bit mem, sf;
        mem = mem_busy();
        sf  = mem || data_hazard();
        if (RST) begin
            if (sf && m_stalls < 65535) m_stalls++;
            if (m_waiting && !MemReadyM) begin
                m_wait_len++;
                if (m_wait_len >= TMO) m_tmo = 1;
            end else if (!m_waiting && mem) begin
                m_wait_len = 0;
            end
            m_waiting = mem;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_in();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemToRegE = 0; MemToRegM = 0;
        BranchD = 0; BranchTakenD = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        tick();
        RST = 1'b1;
        #1;
    endtask

    initial begin
        clear_in();
        RST = 1'b0;
        model_reset();
        #2;
        check_model("por");
        chk("por.cnt0", StallCycles, 16'h0000);
        chk("por.stallf0", 16'(StallF), 16'h0);
        @(negedge CLK);
        RST = 1'b1;
        #1;

        // Forwarding priority: M wins over W, W used once M stops writing.
        WriteRegM = 5; WriteRegW = 5; RsE = 5; RegWriteM = 1; RegWriteW = 1;
        #1;
        chk("fwd.m_wins", 16'(ForwardAE), 16'h2);
        check_model("fwd.m");
        RegWriteM = 0;
        #1;
        chk("fwd.w_only", 16'(ForwardAE), 16'h1);
        check_model("fwd.w");

        // Load-use: one stall cycle then clear.
        clear_in();
        do_reset();
        MemToRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
        #1;
        chk("lw.sf", 16'(StallF), 16'h1);
        chk("lw.fe", 16'(FlushE), 16'h1);
        chk("lw.se", 16'(StallE), 16'h0);
        check_model("lw.hz");
        tick();
        clear_in();
        #1;
        chk("lw.cnt", StallCycles, 16'd1);
        chk("lw.after_sf", 16'(StallF), 16'h0);
        check_model("lw.after");

        // Memory wait of three cycles, released combinationally on ready.
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw.sm", 16'(StallM), 16'h1);
            chk("mw.fw", 16'(FlushW), 16'h1);
            check_model("mw.wait");
            tick();
        end
        MemReadyM = 1;
        #1;
        chk("mw.release_sf", 16'(StallF), 16'h0);
        check_model("mw.ready");
        tick();
        MemReqM = 0; MemReadyM = 0;
        #1;
        chk("mw.back_run_sm", 16'(StallM), 16'h0);
        chk("mw.cnt", StallCycles, 16'd3);
        check_model("mw.run");

        // Taken branch flushes D only when nothing stalls.
        clear_in();
        BranchD = 1; BranchTakenD = 1; RsD = 1; RtD = 2;
        #1;
        chk("br.flushd", 16'(FlushD), 16'h1);
        check_model("br.free");
        MemToRegE = 1; RegWriteE = 1; WriteRegE = 1;
        #1;
        chk("br.lw_flushd", 16'(FlushD), 16'h0);
        chk("br.lw_sf", 16'(StallF), 16'h1);
        check_model("br.lw");
        tick();

        // Watchdog, then reset in the middle of a wait with no clock edge.
        clear_in();
        do_reset();
        MemReqM = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("tmo.early", 16'(MemTimeout), 16'h0);
            tick();
        end
        #1;
`ifdef HZ_MEM_TIMEOUT_EN
        chk("tmo.set", 16'(MemTimeout), 16'h1);
`else
        chk("tmo.tied", 16'(MemTimeout), 16'h0);
`endif
        check_model("tmo.hold");
        MemReadyM = 1;
        tick();
        MemReadyM = 0;
        #1;
        check_model("tmo.sticky");
        tick();
        tick();
        MemReqM = 0;
        #1;
        chk("mid.sm_wait", 16'(StallM), 16'h1);
        RST = 1'b0;
        #1;
        model_reset();
        chk("mid.cnt", StallCycles, 16'h0000);
        chk("mid.tmo", 16'(MemTimeout), 16'h0);
        chk("mid.sm_run", 16'(StallM), 16'h0);
        check_model("mid.rst");
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_model("mid.after");

        // Saturation of the stall counter.
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 65540; i++) tick();
        #1;
        chk("sat.cnt", StallCycles, 16'hFFFF);
        check_model("sat");
        clear_in();
        do_reset();

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            RsD = 5'($urandom_range(0, 3));  RtD = 5'($urandom_range(0, 3));
            RsE = 5'($urandom_range(0, 3));  RtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3));
            WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemToRegE = 1'($urandom); MemToRegM = 1'($urandom);
            BranchD = 1'($urandom); BranchTakenD = BranchD & 1'($urandom);
            MemReqM = ($urandom_range(0, 9) < 3);
            MemReadyM = ($urandom_range(0, 9) < 6);
            RST = ($urandom_range(0, 199) != 0);
            #1;
            if (!RST) model_reset();
            check_model("rnd");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
